temp_scan: RTL and testbench

TEMP_SCAN -- requirements
Module: temp_scan

---
 rtl/temp_scan_if.sv | 34 +++
 rtl/temp_scan.sv | 233 +++++++++++++++++++++++
 tb/tb_temp_scan.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/temp_scan_if.sv
// temp_scan_if: bundles the scan-control, threshold, readback and ADC serial
// signals of temp_scan.
//   slave  : the scanner side (temp_scan).
//   master : the controlling / ADC side (system logic or a testbench).
// Inputs to the scanner : en, hi_thr, lo_thr, sel, dout
// Outputs of the scanner: cs, sclk, din, dataout, valid, ch_id, busy, r, g
interface temp_scan_if #(
   parameter int DW = 10
);
   logic          en;
   logic [DW-1:0] hi_thr;
   logic [DW-1:0] lo_thr;
   logic [2:0]    sel;
   logic          dout;
   logic          cs;
   logic          sclk;
   logic          din;
   logic [DW-1:0] dataout;
   logic          valid;
   logic [2:0]    ch_id;
   logic          busy;
   logic          r;
   logic          g;

   modport slave (
      input  en, hi_thr, lo_thr, sel, dout,
      output cs, sclk, din, dataout, valid, ch_id, busy, r, g
   );

   modport master (
      output en, hi_thr, lo_thr, sel, dout,
      input  cs, sclk, din, dataout, valid, ch_id, busy, r, g
   );
endinterface

// File: rtl/temp_scan.sv
// temp_scan: round-robin temperature scanner for an NCH-channel SPI ADC.
// Each frame selects one channel (start bit, 3-bit address, null bit, DW
// data bits), stores the sample in a per-channel register file and runs an
// over-temperature alarm with hysteresis (set above hi_thr, clear when every
// channel is below lo_thr).
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - temp_scan_if.slave: en/hi_thr/lo_thr/sel/dout in,
//          cs/sclk/din/dataout/valid/ch_id/busy/r/g out
module temp_scan #(
   parameter int NCH    = 4,
   parameter int DW     = 10,
   parameter int CLKDIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   temp_scan_if.slave bus
);

   localparam int NPER = 5 + DW;               // sclk periods per frame
   localparam int CW   = $clog2(4 * CLKDIV);   // wide enough for the GAP count
   localparam int PW   = $clog2(NPER);

   localparam logic [CW-1:0] HALF_LAST = CW'(CLKDIV - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(4 * CLKDIV - 1);
   localparam logic [PW-1:0] PER_LAST  = PW'(NPER - 1);
   localparam logic [PW-1:0] PER_NULL  = PW'(4);
   localparam logic [2:0]    CH_LAST   = 3'(NCH - 1);
   localparam logic [7:0]    CH_MASK   = 8'((1 << NCH) - 1);
   localparam logic [3:0]    NCH_W     = 4'(NCH);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      HOLD  = 3'd3,
      GAP   = 3'd4
   } state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [PW-1:0] per_q;      // current sclk period, 0-based
   logic [2:0]    ptr_q;      // channel addressed by the current/next frame
   logic [DW-1:0] sh_q;
   logic [DW-1:0] last_q;     // sample stored at the most recent valid
   logic [DW-1:0] rf_q [8];   // entries >= NCH are never written and stay 0
   logic [7:0]    sampled_q;
   logic          cs_q;
   logic          sclk_q;
   logic          din_q;
   logic          valid_q;
   logic [2:0]    ch_id_q;
   logic          busy_q;
   logic          r_q;
   logic          g_q;

   logic          all_lo_s;
   logic          set_s;
   logic          r_d;
   logic          g_d;

   // Command bit driven during a given 0-based sclk period: start, address MSB first, then zeros.
   function automatic logic din_bit(input logic [PW-1:0] per, input logic [2:0] addr);
      logic b;
      case (per)
         PW'(0):  b = 1'b1;
         PW'(1):  b = addr[2];
         PW'(2):  b = addr[1];
         PW'(3):  b = addr[0];
         default: b = 1'b0;
      endcase
      return b;
   endfunction

   // Alarm next-state: evaluated only on the cycle valid is high, so threshold edits wait for the next sample.
   always_comb begin
      all_lo_s = 1'b1;
      for (int i = 0; i < NCH; i++) begin
         if (rf_q[i] >= bus.lo_thr) begin
            all_lo_s = 1'b0;
         end else begin
            all_lo_s = all_lo_s;
         end
      end
      set_s = (last_q > bus.hi_thr);
      r_d   = r_q;
      if (valid_q) begin
         if (set_s) begin
            r_d = 1'b1;              // set wins over clear
         end else if (all_lo_s) begin
            r_d = 1'b0;
         end else begin
            r_d = r_q;
         end
      end else begin
         r_d = r_q;
      end
      g_d = ((sampled_q | ~CH_MASK) == 8'hFF) & ~r_d;
   end

   // Frame sequencer, SPI pins, sample capture, register file and alarm registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         per_q     <= '0;
         ptr_q     <= 3'd0;
         sh_q      <= '0;
         last_q    <= '0;
         for (int i = 0; i < 8; i++) begin
            rf_q[i] <= '0;
         end
         sampled_q <= 8'h00;
         cs_q      <= 1'b1;
         sclk_q    <= 1'b0;
         din_q     <= 1'b0;
         valid_q   <= 1'b0;
         ch_id_q   <= 3'd0;
         busy_q    <= 1'b0;
         r_q       <= 1'b0;
         g_q       <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         r_q     <= r_d;
         g_q     <= g_d;
         case (state_q)
            IDLE: begin
               cnt_q  <= '0;
               sclk_q <= 1'b0;
               din_q  <= 1'b0;
               if (bus.en) begin
                  state_q <= SETUP;
                  cs_q    <= 1'b0;
                  busy_q  <= 1'b1;
               end else begin
                  cs_q   <= 1'b1;
                  busy_q <= 1'b0;
               end
            end
            SETUP: begin
               if (cnt_q == HALF_LAST) begin
                  state_q <= SHIFT;
                  cnt_q   <= '0;
                  per_q   <= '0;
                  din_q   <= din_bit(PW'(0), ptr_q);
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            SHIFT: begin
               if (cnt_q == HALF_LAST) begin
                  cnt_q <= '0;
                  if (!sclk_q) begin
                     // Rising sclk: the null period is skipped, data periods shift in MSB first.
                     sclk_q <= 1'b1;
                     if (per_q > PER_NULL) begin
                        sh_q <= {sh_q[DW-2:0], bus.dout};
                     end else begin
                        sh_q <= sh_q;
                     end
                  end else begin
                     // Falling sclk: din only moves here, while sclk is low.
                     sclk_q <= 1'b0;
                     if (per_q == PER_LAST) begin
                        state_q <= HOLD;
                        din_q   <= 1'b0;
                     end else begin
                        per_q <= per_q + 1'b1;
                        din_q <= din_bit(per_q + 1'b1, ptr_q);
                     end
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            HOLD: begin
               if (cnt_q == '0) begin
                  rf_q[ptr_q]      <= sh_q;
                  last_q           <= sh_q;
                  sampled_q[ptr_q] <= 1'b1;
                  ch_id_q          <= ptr_q;
                  valid_q          <= 1'b1;
                  ptr_q            <= (ptr_q == CH_LAST) ? 3'd0 : ptr_q + 3'd1;
               end else begin
                  ptr_q <= ptr_q;
               end
               if (cnt_q == HALF_LAST) begin
                  state_q <= GAP;
                  cs_q    <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            GAP: begin
               if (cnt_q == GAP_LAST) begin
                  cnt_q <= '0;
                  if (bus.en) begin
                     state_q <= SETUP;
                     cs_q    <= 1'b0;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               cs_q    <= 1'b1;
               sclk_q  <= 1'b0;
               din_q   <= 1'b0;
               busy_q  <= 1'b0;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign bus.cs      = cs_q;
   assign bus.sclk    = sclk_q;
   assign bus.din     = din_q;
   assign bus.valid   = valid_q;
   assign bus.ch_id   = ch_id_q;
   assign bus.busy    = busy_q;
   assign bus.r       = r_q;
   assign bus.g       = g_q;
   // Readback of unimplemented channels returns zero.
   assign bus.dataout = ({1'b0, bus.sel} < NCH_W) ? rf_q[bus.sel] : '0;

endmodule

// File: tb/tb_temp_scan.sv
// tb_temp_scan: directed bench for temp_scan with a behavioural SPI ADC that
// decodes the channel address from din and returns a per-channel value.
module tb_temp_scan;
   localparam int NCH    = 4;
   localparam int DW     = 10;
   localparam int CLKDIV = 4;
   localparam int SCAN   = (5 + DW) * 2 * CLKDIV + 6 * CLKDIV;   // 144

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   temp_scan_if #(.DW(DW)) bus ();

   temp_scan #(.NCH(NCH), .DW(DW), .CLKDIV(CLKDIV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // ADC model state
   logic [DW-1:0] adc_val [8];
   int            m_per = 0;
   logic [2:0]    m_addr = 3'd0;
   logic [3:0]    m_hdr = 4'd0;
   logic          m_sclk_prev = 1'b0;
   logic          m_din_prev = 1'b0;
   int            din_bad = 0;

   // ADC model: observes cs/sclk away from the clock edge, decodes header, shifts data out after each falling sclk.
   always @(negedge clk) begin
      logic [DW-1:0] v;
      int            idx;
      if (bus.sclk && m_sclk_prev && (bus.din !== m_din_prev)) din_bad++;
      if (bus.cs !== 1'b0) begin
         m_per = 0;
         bus.dout = 1'b0;
      end else if (bus.sclk && !m_sclk_prev) begin
         m_per++;
         if (m_per <= 4) m_hdr = {m_hdr[2:0], bus.din};
         if (m_per >= 2 && m_per <= 4) m_addr = {m_addr[1:0], bus.din};
      end else if (!bus.sclk && m_sclk_prev) begin
         if (m_per >= 5 && m_per < 5 + DW) begin
            v   = adc_val[m_addr];
            idx = DW - 1 - (m_per - 5);
            bus.dout = v[idx];
         end else begin
            bus.dout = 1'b0;
         end
      end
      m_sclk_prev = bus.sclk;
      m_din_prev  = bus.din;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_valid(input int limit, output int t);
      int k = 0;
      @(negedge clk);
      while (bus.valid !== 1'b1 && k < limit) begin
         @(negedge clk);
         k++;
      end
      chk("valid_seen", {31'd0, bus.valid}, 32'd1);
      t = cyc;
   endtask

   task automatic wait_ch(input logic [2:0] ch);
      int t;
      int n = 0;
      wait_valid(400, t);
      while (bus.ch_id !== ch && n < 6) begin
         wait_valid(400, t);
         n++;
      end
      chk("wait_ch_id", {29'd0, bus.ch_id}, {29'd0, ch});
      @(negedge clk);   // alarm outputs settle one cycle after valid
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t, t_prev, k, nv;
      rst        = 1'b0;
      bus.en     = 1'b0;
      bus.hi_thr = 10'h3FF;
      bus.lo_thr = 10'd0;
      bus.sel    = 3'd0;
      bus.dout   = 1'b0;
      for (int i = 0; i < 8; i++) adc_val[i] = 10'd400;
      adc_val[2] = 10'h2A5;
      t_prev = 0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_cs", bus.cs, 1);
      chk("rst_sclk", bus.sclk, 0);
      chk("rst_din", bus.din, 0);
      chk("rst_valid", bus.valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_r", bus.r, 0);
      chk("rst_g", bus.g, 0);
      chk("rst_ch_id", bus.ch_id, 0);
      chk("rst_dataout", bus.dataout, 0);

      rst = 1'b1;
      @(negedge clk);
      bus.en = 1'b1;

      // five frames: addresses 0,1,2,3,0, fixed spacing, header and readback of channel 2
      for (int f = 0; f < 5; f++) begin
         wait_valid(400, t);
         chk($sformatf("ch_id_f%0d", f), bus.ch_id, f % 4);
         chk($sformatf("adc_addr_f%0d", f), m_addr, f % 4);
         chk($sformatf("busy_f%0d", f), bus.busy, 1);
         if (f > 0) chk($sformatf("spacing_f%0d", f), t - t_prev, SCAN);
         t_prev = t;
         if (f == 2) begin
            chk("hdr_ch2", m_hdr, 4'b1010);
            bus.sel = 3'd2;
            #1;
            chk("dataout_ch2", bus.dataout, 10'h2A5);
         end
         @(negedge clk);
         chk($sformatf("valid_1cyc_f%0d", f), bus.valid, 0);
         chk($sformatf("g_f%0d", f), bus.g, (f >= 3) ? 1 : 0);
      end
      bus.sel = 3'd5;
      #1;
      chk("sel_oob", bus.dataout, 0);
      bus.sel = 3'd2;

      // alarm hysteresis on channel 1
      bus.hi_thr = 10'd600;
      bus.lo_thr = 10'd500;
      adc_val[2] = 10'd400;
      adc_val[1] = 10'd601;
      wait_ch(3'd1);
      chk("r_set_601", bus.r, 1);
      chk("g_with_r", bus.g, 0);
      adc_val[1] = 10'd550;
      wait_ch(3'd1);
      chk("r_hold_550", bus.r, 1);
      adc_val[1] = 10'd499;
      wait_ch(3'd1);
      chk("r_clr_499", bus.r, 0);
      chk("g_after_clr", bus.g, 1);
      adc_val[1] = 10'd600;
      wait_ch(3'd1);
      chk("r_eq_hi", bus.r, 0);
      adc_val[1] = 10'd700;
      wait_ch(3'd1);
      chk("r_set_700", bus.r, 1);
      adc_val[1] = 10'd500;
      wait_ch(3'd1);
      chk("r_eq_lo", bus.r, 1);

      // threshold edit must wait for the next valid
      bus.lo_thr = 10'd1000;
      repeat (5) @(negedge clk);
      chk("thr_no_reeval", bus.r, 1);
      wait_ch(3'd2);
      chk("r_clr_new_lo", bus.r, 0);

      // misconfigured thresholds: set wins
      bus.hi_thr = 10'd450;
      adc_val[1] = 10'd460;
      wait_ch(3'd1);
      chk("r_set_wins", bus.r, 1);

      // en dropped mid data bits of the channel 2 frame
      adc_val[2] = 10'h155;
      k = 0;
      while (bus.cs !== 1'b0 && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("cs_low_seen", bus.cs, 0);
      repeat (CLKDIV + 9 * 2 * CLKDIV) @(negedge clk);
      bus.en = 1'b0;
      wait_valid(200, t);
      chk("endrop_ch_id", bus.ch_id, 2);
      #1;
      chk("endrop_data", bus.dataout, 10'h155);
      k = 0;
      while (bus.busy !== 1'b0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("busy_fall_lat", k, 19);
      chk("endrop_cs", bus.cs, 1);
      nv = 0;
      repeat (300) begin
         @(negedge clk);
         if (bus.valid === 1'b1) nv++;
      end
      chk("no_more_valid", nv, 0);
      chk("idle_busy", bus.busy, 0);

      // reset asserted while sclk is high in SHIFT
      bus.en = 1'b1;
      k = 0;
      while (bus.cs !== 1'b0 && k < 50) begin
         @(negedge clk);
         k++;
      end
      repeat (30) @(negedge clk);
      k = 0;
      while (bus.sclk !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("pre_rst_sclk_high", bus.sclk, 1);
      #2 rst = 1'b0;
      #1;
      chk("async_cs", bus.cs, 1);
      chk("async_sclk", bus.sclk, 0);
      chk("async_busy", bus.busy, 0);
      chk("rst_rf_ch2", bus.dataout, 0);
      bus.sel = 3'd1;
      #1;
      chk("rst_rf_ch1", bus.dataout, 0);
      @(negedge clk);
      rst = 1'b1;
      wait_valid(400, t);
      chk("post_rst_ch_id", bus.ch_id, 0);
      chk("post_rst_addr", m_addr, 0);

      chk("din_stable", din_bad, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
